// File: rtl/deadlock_idx0_monitor.sv
// Deadlock detector for the top-level dataflow region: raises block when the same
// non-empty set of stalled AXIS ports / blocked child instances persists for BLOCK_THRESHOLD cycles.
module deadlock_idx0_monitor #(
  parameter int NUM_AXIS        = 2,
  parameter int NUM_INST        = 1,
  parameter int BLOCK_THRESHOLD = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  output logic                block
);

  localparam int VW = NUM_AXIS + NUM_INST;
  localparam int CW = $clog2(BLOCK_THRESHOLD + 1);
  localparam logic [CW-1:0] THR   = CW'(BLOCK_THRESHOLD);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [VW-1:0] r_prev_vec;
  logic [CW-1:0] r_cnt;
  logic          r_block;

  logic [VW-1:0] w_cur_vec;
  logic [CW-1:0] w_cnt_next;
  logic          w_block_next;

  // An idle child cannot be part of a deadlock, whatever its block bit says.
  assign w_cur_vec = {inst_block_sigs & ~inst_idle_sigs, axis_block_sigs};

  always_comb begin
    w_cnt_next   = '0;
    w_block_next = 1'b0;
    if (w_cur_vec == '0) begin
      w_cnt_next   = '0;
      w_block_next = 1'b0;
    end else if (w_cur_vec != r_prev_vec) begin
      // A new or changed stall pattern counts as progress: restart at one sample.
      w_cnt_next   = ONE_C;
      w_block_next = (THR <= ONE_C);
    end else begin
      // Saturate at the threshold so a long-lived deadlock never wraps the count.
      w_cnt_next   = (r_cnt >= THR) ? THR : r_cnt + ONE_C;
      w_block_next = (w_cnt_next >= THR);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_prev_vec <= '0;
      r_cnt      <= '0;
      r_block    <= 1'b0;
    end else begin
      r_prev_vec <= w_cur_vec;
      r_cnt      <= w_cnt_next;
      r_block    <= w_block_next;
    end
  end

  assign block = r_block;

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
// Bench for deadlock_idx0_monitor: directed scenarios plus random stimulus, with
// threshold-4 and threshold-1 instances checked against a sample-history model.
module tb_deadlock_idx0_monitor;

  localparam int NA = 2;
  localparam int NI = 1;
  localparam int VW = NA + NI;

  // clock / reset block
  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NA-1:0] axis  = '0;
  logic [NI-1:0] idle  = '0;
  logic [NI-1:0] blk   = '0;
  logic          block4;
  logic          block1;

  always #5 clock = ~clock;

  deadlock_idx0_monitor #(.NUM_AXIS(NA), .NUM_INST(NI), .BLOCK_THRESHOLD(4)) u_dut4 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis),
    .inst_idle_sigs(idle), .inst_block_sigs(blk), .block(block4)
  );

  deadlock_idx0_monitor #(.NUM_AXIS(NA), .NUM_INST(NI), .BLOCK_THRESHOLD(1)) u_dut1 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis),
    .inst_idle_sigs(idle), .inst_block_sigs(blk), .block(block1)
  );

  // scoreboard: history of blocked-vector samples taken since the last reset
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [VW-1:0] hist[$];

  // Deadlock = the last thr samples exist, are identical and are non-zero.
  function automatic logic model_block(int thr);
    logic [VW-1:0] last;
    if (hist.size() < thr) return 1'b0;
    last = hist[hist.size()-1];
    if (last == '0) return 1'b0;
    for (int i = 1; i <= thr; i++)
      if (hist[hist.size()-i] != last) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver: apply inputs for one edge, update the model, then check both DUTs
  task automatic step(input logic [NA-1:0] a, input logic [NI-1:0] i_idle,
                      input logic [NI-1:0] i_blk, input logic rstn);
    axis  = a;
    idle  = i_idle;
    blk   = i_blk;
    reset = rstn;
    @(posedge clock);
    if (!rstn) hist.delete();
    else begin
      hist.push_back({i_blk & ~i_idle, a});
      if (hist.size() > 80) void'(hist.pop_front());
    end
    #1;
    check_eq("model_thr4", block4, model_block(4));
    check_eq("model_thr1", block1, model_block(1));
  endtask

  initial begin
    logic [NA-1:0] ra;
    logic [NI-1:0] ri, rb;
    int            hold;

    // Reset held with a stall present
    for (int k = 0; k < 3; k++) begin
      step(2'b11, 1'b0, 1'b0, 1'b0);
      check_eq("reset_hold", block4, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 1'b0, 1'b0, 1'b1);
      check_eq("reset_release", block4, (k == 3));
    end
    step(2'b00, 1'b0, 1'b0, 1'b1);
    check_eq("clear_zero", block4, 1'b0);

    // Persistent stall, hold, release
    for (int k = 0; k <= 20; k++) begin
      step(2'b01, 1'b0, 1'b0, 1'b1);
      check_eq("persist", block4, (k >= 3));
    end
    step(2'b00, 1'b0, 1'b0, 1'b1);
    check_eq("persist_release", block4, 1'b0);

    // Pattern change restarts the count
    for (int k = 0; k < 3; k++) begin
      step(2'b01, 1'b0, 1'b0, 1'b1);
      check_eq("pat_a", block4, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      step(2'b10, 1'b0, 1'b0, 1'b1);
      check_eq("pat_b", block4, 1'b0);
    end
    step(2'b10, 1'b0, 1'b0, 1'b1);
    check_eq("pat_b_fourth", block4, 1'b1);
    step(2'b00, 1'b0, 1'b0, 1'b1);

    // Idle masking
    for (int k = 0; k < 10; k++) begin
      step(2'b00, 1'b1, 1'b1, 1'b1);
      check_eq("idle_mask", block4, 1'b0);
      check_eq("idle_mask_t1", block1, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      step(2'b00, 1'b0, 1'b1, 1'b1);
      check_eq("idle_drop", block4, (k == 3));
    end

    // Mid-operation reset with the stall unchanged
    step(2'b00, 1'b0, 1'b1, 1'b0);
    check_eq("mid_reset", block4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(2'b00, 1'b0, 1'b1, 1'b1);
      check_eq("mid_reset_rearm", block4, (k == 3));
    end

    // Threshold 1: any non-zero vector blocks after one edge
    step(2'b00, 1'b0, 1'b0, 1'b1);
    check_eq("thr1_zero", block1, 1'b0);
    step(2'b10, 1'b0, 1'b0, 1'b1);
    check_eq("thr1_first", block1, 1'b1);
    step(2'b01, 1'b0, 1'b0, 1'b1);
    check_eq("thr1_change", block1, 1'b1);

    // Short-stall filtering
    for (int k = 0; k < 50; k++) begin
      step((k % 2 == 0) ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b1);
      check_eq("short_stall", block4, 1'b0);
    end

    // Random: held patterns of random length, occasional resets
    for (int k = 0; k < 300; k++) begin
      ra   = NA'($urandom_range(0, 3));
      ri   = NI'($urandom_range(0, 1));
      rb   = NI'($urandom_range(0, 1));
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++)
        step(ra, ri, rb, ($urandom_range(0, 49) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/deadlock_idx0_monitor.md
Name: deadlock_idx0_monitor

Overview:
- Per-kernel deadlock detector for the top-level dataflow region (index 0).
- Watches the blocking status of the kernel's AXI-Stream ports and of its child process instances.
- Asserts `block` when the same non-empty set of blocking conditions persists, unchanged, for a programmable number of consecutive clock cycles.
- Used by the kernel-level monitor, which reports "find kernel block." on the rising edge of `block`.

Parameters:
- NUM_AXIS, 2, number of AXI-Stream blocking inputs (width of axis_block_sigs); must be at least 1.
- NUM_INST, 1, number of child-instance idle/block input pairs; must be at least 1.
- BLOCK_THRESHOLD, 64, consecutive unchanged blocked cycles required before `block` asserts; must be at least 1.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset.
- axis_block_sigs  input  NUM_AXIS  bit i = 1 means AXIS channel i is stalled this cycle (already inverted blk_n).
- inst_idle_sigs  input  NUM_INST  bit j = 1 means child instance j is idle.
- inst_block_sigs  input  NUM_INST  bit j = 1 means child instance j reports blocked.
- block  output  1  registered deadlock indication.

Behaviour:
- Combinational blocked vector: cur_vec = {inst_block_sigs & ~inst_idle_sigs, axis_block_sigs}, width NUM_AXIS+NUM_INST.
  - An idle instance never contributes, even if its block bit is 1.
- State registers:
  - prev_vec: NUM_AXIS+NUM_INST bits.
  - cnt: saturating counter, width clog2(BLOCK_THRESHOLD+1).
  - block.
- Reset: on a rising edge with reset==0, set prev_vec=0, cnt=0, block=0. Reset overrides all other activity, including mid-count and while block=1.
- Each rising edge with reset==1 applies exactly one of these cases:
  - cur_vec==0: cnt<=0, block<=0.
  - cur_vec!=0 and cur_vec!=prev_vec (new or changed stall pattern, treated as progress): cnt<=1, block<=(1>=BLOCK_THRESHOLD).
  - cur_vec!=0 and cur_vec==prev_vec: cnt_next=min(cnt+1, BLOCK_THRESHOLD); cnt<=cnt_next; block<=(cnt_next>=BLOCK_THRESHOLD).
  - In every case, prev_vec<=cur_vec.
- Latency: with a constant non-zero vector first sampled at edge k, block rises after edge k+BLOCK_THRESHOLD-1, i.e. once BLOCK_THRESHOLD samples have been taken.
  - BLOCK_THRESHOLD=1: block rises after the first blocked edge.
- Hold and release:
  - block stays 1 while the vector stays constant and non-zero; the counter saturates and never wraps.
  - block clears after the first edge where the vector becomes zero or changes value.
  - A changed non-zero vector restarts the count at 1.
- Inputs are sampled only at clock edges; glitches between edges are ignored.
- No combinational path from any input to `block`.
- X on inputs is not filtered. The bench drives known values after reset.

Test Plan:
- All inputs are driven synchronously to clock. Scenarios use BLOCK_THRESHOLD=4, NUM_AXIS=2, NUM_INST=1 unless a different value is stated.
- Reset: hold reset=0 for 3 edges with axis_block_sigs=2'b11 -> block=0 throughout; release -> block=1 after exactly 4 further edges.
- Persistent stall: axis_block_sigs=2'b01 constant from edge 0 -> block=0 after edges 0-2, block=1 after edge 3 and held through edge 20. Then axis_block_sigs=0 -> block=0 after the next edge.
- Pattern change restarts the count: 2'b01 for 3 edges, then 2'b10 for 3 edges -> block never asserts. Keep 2'b10 for one more edge (4 total) -> block=1.
- Idle masking: inst_block_sigs=1, inst_idle_sigs=1, axis=0 for 10 edges -> block=0. Drop inst_idle_sigs to 0 -> block=1 after 4 edges.
- Mid-operation reset and edge thresholds:
  - block=1, then assert reset=0 for 1 edge -> block=0 on that edge; with the stall unchanged, block re-asserts 4 edges after reset release.
  - With BLOCK_THRESHOLD=1: any non-zero vector -> block=1 after the first edge.
- Short-stall filtering: alternating axis_block_sigs 2'b01 and 2'b00 every edge for 50 edges -> block stays 0.
